// File: rtl/x25519_mult_serial.sv
// Digit-serial a*b mod 2^255-19, consuming DIGIT_BITS of b per cycle MSB-first.
// Latency 256/DIGIT_BITS+1 cycles; X25519_MULT_FINAL_REDUCE_EN adds one cycle and canonical output.
// No backpressure: in_ready is low while busy, en is ignored then, out_valid is a one-cycle pulse.
module x25519_mult_serial #(
   parameter int DIGIT_BITS = 8,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [263:0]         a,
   input  logic [263:0]         b,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [263:0]         out,
   output logic [TAG_WIDTH-1:0] tag_out
);
   localparam int N  = 256 / DIGIT_BITS;
   localparam int AW = 257 + DIGIT_BITS;
   localparam logic [7:0] LAST = 8'(N - 1);

   generate
      if (DIGIT_BITS != 1 && DIGIT_BITS != 2 && DIGIT_BITS != 4 &&
          DIGIT_BITS != 8 && DIGIT_BITS != 16 && DIGIT_BITS != 32) begin : g_bad_digit_bits
         $error("x25519_mult_serial: DIGIT_BITS must be 1, 2, 4, 8, 16 or 32");
      end
   endgenerate

`ifdef X25519_MULT_FINAL_REDUCE_EN
   localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};
   typedef enum logic [1:0] {IDLE, MUL, FOLD, FINAL} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, FOLD} state_t;
`endif

   state_t                state_q;
   logic [255:0]          a_q;
   logic [255:0]          b_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [AW-1:0]         acc_q;
   logic [7:0]            cnt_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic [263:0]          out_q;
   logic [TAG_WIDTH-1:0]  tag_out_q;

   logic [DIGIT_BITS-1:0] digit;
   logic [255+DIGIT_BITS:0] prod;
   logic [AW:0]           mul_full;
   logic                  mul_ovf;
   logic [AW-1:0]         acc_d;
   logic [AW-1:0]         fold1;
   logic [AW-1:0]         fold2;
   logic [255:0]          fold_d;
   logic                  unused_hi;

   assign digit    = b_q[255 -: DIGIT_BITS];
   assign prod     = {{DIGIT_BITS{1'b0}}, a_q} * {{256{1'b0}}, digit};
   assign mul_full = {1'b0, acc_q[256:0], {DIGIT_BITS{1'b0}}} + {2'b00, prod};
   // acc stays below 2^256 between digits; anything above that would be silently lost.
   assign mul_ovf  = mul_full[AW] | (|acc_q[AW-1:257]);
   assign acc_d    = AW'(mul_full[254:0]) + AW'(mul_full[AW-1:255]) * AW'(19);

   assign fold1  = AW'(acc_q[254:0]) + AW'(acc_q[AW-1:255]) * AW'(19);
   assign fold2  = AW'(fold1[254:0]) + AW'(fold1[AW-1:255]) * AW'(19);
   assign fold_d = {1'b0, fold2[254:0]} + (fold2[255] ? 256'd19 : 256'd0);

`ifdef X25519_MULT_FINAL_REDUCE_EN
   logic [255:0] fin_d;
   assign fin_d = (acc_q[255:0] >= P) ? (acc_q[255:0] - P) : acc_q[255:0];
`endif

   assign unused_hi = ^{a[263:256], b[263:256], fold2[AW-1:256]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         tag_out_q   <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  a_q        <= a[255:0];
                  b_q        <= b[255:0];
                  tag_q      <= tag_in;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               acc_q <= acc_d;
               b_q   <= {b_q[255-DIGIT_BITS:0], {DIGIT_BITS{1'b0}}};
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == LAST) state_q <= FOLD;
            end
`ifdef X25519_MULT_FINAL_REDUCE_EN
            FOLD: begin
               acc_q   <= AW'(fold_d);
               state_q <= FINAL;
            end
            FINAL: begin
               out_q       <= {8'd0, fin_d};
               tag_out_q   <= tag_q;
               out_valid_q <= 1'b1;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
`else
            FOLD: begin
               out_q       <= {8'd0, fold_d};
               tag_out_q   <= tag_q;
               out_valid_q <= 1'b1;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst) (state_q == MUL) |-> !mul_ovf);

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_x25519_mult_serial.sv
// Bench for x25519_mult_serial: directed table, random ops against a plain modular-arithmetic model,
// back-to-back handshake, and reset/abort sequences; works with or without X25519_MULT_FINAL_REDUCE_EN.
module tb_x25519_mult_serial;
   localparam int DB = 8;
   localparam int TW = 8;
   localparam int N  = 256 / DB;
`ifdef X25519_MULT_FINAL_REDUCE_EN
   localparam int L = N + 2;
`else
   localparam int L = N + 1;
`endif
   localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [263:0]  a;
   logic [263:0]  b;
   logic [TW-1:0] tag_in;
   logic          in_ready;
   logic          out_valid;
   logic [263:0]  out;
   logic [TW-1:0] tag_out;

   x25519_mult_serial #(.DIGIT_BITS(DB), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .tag_in(tag_in),
      .in_ready(in_ready), .out_valid(out_valid), .out(out), .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [263:0] a;
      logic [263:0] b;
      logic [255:0] exp;
   } vec_t;

   vec_t          vecs[8];
   int            pass_cnt = 0;
   int            total_cnt = 0;
   logic [263:0]  res;
   logic [TW-1:0] rtag;
   int            lat;
   logic [263:0]  ra, rb;
   logic [255:0]  rexp;
   logic [TW-1:0] exp_tags[$];
   logic [TW-1:0] got_tags[$];
   logic [263:0]  got_outs[$];
   int            next_free;
   int            nvalid;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input bit ok, input string nm, input logic [263:0] act, input logic [263:0] expv);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, expv);
   endtask

   function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
      logic [511:0] pr;
      pr = {256'd0, x} * {256'd0, y};
      return 256'(pr % {256'd0, P});
   endfunction

   // Non-canonical builds only promise a value below 2^255 that is congruent mod p.
   function automatic bit res_ok(input logic [263:0] got, input logic [255:0] expv);
`ifdef X25519_MULT_FINAL_REDUCE_EN
      return got == {8'd0, expv};
`else
      logic [263:0] r;
      r = got % {8'd0, P};
      return (got[263:255] == 9'd0) && (r == {8'd0, expv});
`endif
   endfunction

   function automatic logic [263:0] rand264();
      logic [287:0] t;
      for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
      return t[263:0];
   endfunction

   task automatic run_op(input logic [263:0] aa, input logic [263:0] bb, input logic [TW-1:0] tg,
                         output logic [263:0] r, output logic [TW-1:0] rt, output int lt);
      a = aa; b = bb; tag_in = tg; en = 1'b1;
      tick();
      en = 1'b0; a = ~aa; b = ~bb; tag_in = ~tg;
      lt = -1;
      for (int n = 1; n <= 4 * L; n++) begin
         tick();
         if (out_valid) begin
            lt = n;
            break;
         end
      end
      r = out; rt = tag_out;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; a = '0; b = '0; tag_in = '0;
      tick(); tick(); tick();
      chk(in_ready == 1'b1, "reset in_ready", 264'(in_ready), 264'd1);
      chk(out_valid == 1'b0, "reset out_valid", 264'(out_valid), 264'd0);
      chk(out == 264'd0, "reset out", out, 264'd0);
      chk(tag_out == '0, "reset tag_out", 264'(tag_out), 264'd0);
      rst = 1'b0;
      tick();

      vecs[0] = '{264'd2, 264'd3, 256'd6};
      vecs[1] = '{264'h00dc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967,
                  264'h00873d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6, 256'd0};
      vecs[1].exp = ref_mul(vecs[1].a[255:0], vecs[1].b[255:0]);
      vecs[2] = '{{8'd0, P - 256'd1}, {8'd0, P - 256'd1}, 256'd1};
      vecs[3] = '{264'd1 << 255, 264'd1, 256'd19};
      // 2^256-1 is 37 mod p, so its square reduces to 1369.
      vecs[4] = '{{8'd0, {256{1'b1}}}, {8'd0, {256{1'b1}}}, 256'd1369};
      vecs[5] = '{264'd0, 264'h00f00dcafe123456789abcdef0123456789abcdef0123456789abcdef0123456789, 256'd0};
      vecs[6] = '{{8'd0, P}, 264'd1, 256'd0};
      vecs[7] = '{{8'hff, 256'd5}, {8'ha5, 256'd7}, 256'd35};

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, TW'(i + 5), res, rtag, lat);
         chk(res_ok(res, vecs[i].exp), $sformatf("vec%0d out", i), res, {8'd0, vecs[i].exp});
         chk(rtag == TW'(i + 5), $sformatf("vec%0d tag", i), 264'(rtag), 264'(i + 5));
         chk(lat == L, $sformatf("vec%0d latency", i), 264'(lat), 264'(L));
         tick();
         chk(out_valid == 1'b0, $sformatf("vec%0d pulse width", i), 264'(out_valid), 264'd0);
      end

      for (int i = 0; i < 12; i++) begin
         ra = rand264(); rb = rand264();
         rexp = ref_mul(ra[255:0], rb[255:0]);
         run_op(ra, rb, TW'($urandom), res, rtag, lat);
         chk(res_ok(res, rexp) && lat == L, $sformatf("rand%0d out", i), res, {8'd0, rexp});
      end

      // en held high with a per-cycle tag: a strobe is taken only when the block is idle.
      ra = rand264(); rb = rand264();
      rexp = ref_mul(ra[255:0], rb[255:0]);
      next_free = 0;
      for (int i = 0; i < 3 * L; i++) begin
         if (i >= next_free) begin
            exp_tags.push_back(TW'(i));
            next_free = i + L + 1;
         end
      end
      for (int i = 0; i < 4 * L + 4; i++) begin
         en = (i < 3 * L); tag_in = TW'(i); a = ra; b = rb;
         tick();
         if (out_valid) begin
            got_tags.push_back(tag_out);
            got_outs.push_back(out);
         end
      end
      en = 1'b0;
      chk(got_tags.size() == 3 && exp_tags.size() == 3, "burst product count",
          264'(got_tags.size()), 264'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < got_tags.size()) begin
            chk(got_tags[i] == exp_tags[i], $sformatf("burst tag%0d", i), 264'(got_tags[i]), 264'(exp_tags[i]));
            chk(res_ok(got_outs[i], rexp), $sformatf("burst out%0d", i), got_outs[i], {8'd0, rexp});
         end
      end

      // Abort mid-MUL.
      a = vecs[1].a; b = vecs[1].b; tag_in = 8'h3c; en = 1'b1;
      tick();
      en = 1'b0;
      repeat (N / 2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(in_ready == 1'b1, "abort in_ready", 264'(in_ready), 264'd1);
      chk(out == 264'd0, "abort out", out, 264'd0);
      chk(tag_out == '0, "abort tag_out", 264'(tag_out), 264'd0);
      nvalid = 0;
      for (int i = 0; i < L + 4; i++) begin
         tick();
         if (out_valid) nvalid++;
      end
      chk(nvalid == 0, "abort no out_valid", 264'(nvalid), 264'd0);
      run_op(vecs[1].a, vecs[1].b, 8'h77, res, rtag, lat);
      chk(res_ok(res, vecs[1].exp) && rtag == 8'h77, "after abort out", res, {8'd0, vecs[1].exp});

      // rst and en together: the strobe is dropped.
      a = vecs[0].a; b = vecs[0].b; tag_in = 8'h11; en = 1'b1; rst = 1'b1;
      tick();
      en = 1'b0; rst = 1'b0;
      tick();
      chk(in_ready == 1'b1, "rst+en in_ready", 264'(in_ready), 264'd1);
      nvalid = 0;
      for (int i = 0; i < L + 4; i++) begin
         tick();
         if (out_valid) nvalid++;
      end
      chk(nvalid == 0, "rst+en no out_valid", 264'(nvalid), 264'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
